// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD responder: command opcodes/masks, FSM state encoding,
// and address-counter helpers for the two-line 16-character DDRAM layout.
package lcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_BUSY = 2'd2
  } lcd_state_e;

  localparam logic [7:0] OPC_CLEAR     = 8'h01;
  localparam logic [7:0] MSK_CLEAR     = 8'hFF;
  localparam logic [7:0] OPC_HOME      = 8'h02;
  localparam logic [7:0] MSK_HOME      = 8'hFE;
  localparam logic [7:0] OPC_ENTRY     = 8'h04;
  localparam logic [7:0] MSK_ENTRY     = 8'hFC;
  localparam logic [7:0] OPC_DISP      = 8'h08;
  localparam logic [7:0] MSK_DISP      = 8'hF8;
  localparam logic [7:0] OPC_CURSOR    = 8'h10;
  localparam logic [7:0] MSK_CURSOR    = 8'hF8;
  localparam logic [7:0] OPC_SET_DDRAM = 8'h80;
  localparam logic [7:0] MSK_SET_DDRAM = 8'h80;

  localparam logic [7:0] BLANK_CHAR  = 8'h20;
  localparam logic [4:0] FILL_LAST   = 5'd31;

  localparam logic [6:0] AC_L0_FIRST = 7'h00;
  localparam logic [6:0] AC_L0_LAST  = 7'h0F;
  localparam logic [6:0] AC_L1_FIRST = 7'h40;
  localparam logic [6:0] AC_L1_LAST  = 7'h4F;

  function automatic logic is_op(input logic [7:0] d, input logic [7:0] opc,
                                 input logic [7:0] msk);
    return (d & msk) == opc;
  endfunction

  // Lines are 16 cells each; the counter jumps between line ends instead of walking the gap.
  function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
    logic [6:0] r;
    if (inc) begin
      if (ac == AC_L0_LAST)      r = AC_L1_FIRST;
      else if (ac == AC_L1_LAST) r = AC_L0_FIRST;
      else                       r = ac + 7'd1;
    end else begin
      if (ac == AC_L0_FIRST)      r = AC_L1_LAST;
      else if (ac == AC_L1_FIRST) r = AC_L0_LAST;
      else                        r = ac - 7'd1;
    end
    return r;
  endfunction

  function automatic logic [4:0] ddram_idx(input logic [6:0] ac);
    return {ac[6], ac[3:0]};
  endfunction

  function automatic logic [6:0] set_ddram_ac(input logic [7:0] d);
    return {d[6], 2'b00, d[3:0]};
  endfunction

endpackage

// File: rtl/lcd_ddram.sv
// 32x8 character RAM: one write port, two independent synchronous read ports
// (display scan and controller read-back). Contents are not reset.
module lcd_ddram (
  input  logic       clk,
  input  logic       we,
  input  logic [4:0] waddr,
  input  logic [7:0] wdata,
  input  logic [4:0] raddr_a,
  output logic [7:0] rdata_a,
  input  logic [4:0] raddr_b,
  output logic [7:0] rdata_b
);

  logic [7:0] mem [32];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata_a <= mem[raddr_a];
    rdata_b <= mem[raddr_b];
  end

endmodule

// File: rtl/lcd_responder.sv
// HD44780-style LCD responder: synchronized bus, command/data decode, busy timing, 32-char DDRAM.
// Read-back of status and DDRAM is built only when LCD_RESPONDER_READ_EN is defined.
//
// state   | meaning
// ST_IDLE | ready; a write strobe is decoded and executed
// ST_FILL | clear in progress; one DDRAM cell blanked per cycle
// ST_BUSY | command executing; down-counter runs to terminal count
module lcd_responder
  import lcd_pkg::*;
#(
  parameter int BUSY_CYCLES  = 40,
  parameter int CLEAR_CYCLES = 1600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       e,
  input  logic       rs,
  input  logic       rw,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic       busy,
  output logic       overrun,
  input  logic [4:0] scan_addr,
  output logic [7:0] scan_char
);

  localparam int CNT_MAX = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
  localparam int TW      = $clog2(CNT_MAX) + 1;
  localparam logic [TW-1:0] LD_BUSY  = TW'(BUSY_CYCLES - 1);
  localparam logic [TW-1:0] LD_CLEAR = TW'(CLEAR_CYCLES - 1);

  logic [10:0] sync1, sync2;
  logic        e_d;
  logic        e_s, rs_s, rw_s;
  logic [7:0]  data_s;
  logic        strobe, wr_stb;

  lcd_state_e  state, state_nx;
  logic [6:0]  ac, ac_nx;
  logic        id, id_nx;
  // Display-on bit is held for completeness; nothing inside the responder consumes it.
  logic        disp_on_unused, disp_nx;
  logic [TW-1:0] cnt, cnt_nx;
  logic [4:0]  fill_idx, fill_nx;

  logic        we;
  logic [4:0]  waddr;
  logic [7:0]  wdata;
  logic [4:0]  ac_idx;
`ifdef LCD_RESPONDER_READ_EN
  logic [7:0]  ac_char;
`else
  logic [7:0]  ac_char_unused;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      e_d   <= 1'b0;
    end else begin
      sync1 <= {e, rs, rw, data_in};
      sync2 <= sync1;
      e_d   <= sync2[10];
    end
  end

  assign {e_s, rs_s, rw_s, data_s} = sync2;
  assign strobe = e_d & ~e_s;
  assign wr_stb = strobe & ~rw_s;
  assign busy   = (state != ST_IDLE);
  assign ac_idx = ddram_idx(ac);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      ac             <= '0;
      id             <= 1'b1;
      disp_on_unused <= 1'b0;
      cnt            <= '0;
      fill_idx       <= '0;
      overrun        <= 1'b0;
    end else begin
      state          <= state_nx;
      ac             <= ac_nx;
      id             <= id_nx;
      disp_on_unused <= disp_nx;
      cnt            <= cnt_nx;
      fill_idx       <= fill_nx;
      if (wr_stb && busy) overrun <= 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    ac_nx    = ac;
    id_nx    = id;
    disp_nx  = disp_on_unused;
    cnt_nx   = cnt;
    fill_nx  = fill_idx;
    we       = 1'b0;
    waddr    = ac_idx;
    wdata    = data_s;
    case (state)
      ST_IDLE: begin
        if (wr_stb) begin
          state_nx = ST_BUSY;
          cnt_nx   = LD_BUSY;
          if (rs_s) begin
            we    = 1'b1;
            ac_nx = ac_step(ac, id);
          end else if (is_op(data_s, OPC_CLEAR, MSK_CLEAR)) begin
            ac_nx    = '0;
            id_nx    = 1'b1;
            fill_nx  = '0;
            state_nx = ST_FILL;
          end else if (is_op(data_s, OPC_HOME, MSK_HOME)) begin
            ac_nx  = '0;
            cnt_nx = LD_CLEAR;
          end else if (is_op(data_s, OPC_ENTRY, MSK_ENTRY)) begin
            id_nx = data_s[1];
          end else if (is_op(data_s, OPC_DISP, MSK_DISP)) begin
            disp_nx = data_s[2];
          end else if (is_op(data_s, OPC_CURSOR, MSK_CURSOR)) begin
            ac_nx = ac_step(ac, data_s[2]);
          end else if (is_op(data_s, OPC_SET_DDRAM, MSK_SET_DDRAM)) begin
            ac_nx = set_ddram_ac(data_s);
          end
        end
      end
      ST_FILL: begin
        we      = 1'b1;
        waddr   = fill_idx;
        wdata   = BLANK_CHAR;
        fill_nx = fill_idx + 5'd1;
        if (fill_idx == FILL_LAST) begin
          state_nx = ST_BUSY;
          cnt_nx   = LD_CLEAR;
        end
      end
      ST_BUSY: begin
        if (cnt == '0) state_nx = ST_IDLE;
        else           cnt_nx   = cnt - TW'(1);
      end
      default: state_nx = ST_IDLE;
    endcase
`ifdef LCD_RESPONDER_READ_EN
    // Data reads advance the counter even while a command is still executing.
    if (strobe && rw_s && rs_s) ac_nx = ac_step(ac, id);
`endif
  end

  lcd_ddram u_ddram (
    .clk     (clk),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .raddr_a (scan_addr),
    .rdata_a (scan_char),
    .raddr_b (ac_idx),
`ifdef LCD_RESPONDER_READ_EN
    .rdata_b (ac_char)
`else
    .rdata_b (ac_char_unused)
`endif
  );

`ifdef LCD_RESPONDER_READ_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out <= '0;
      data_oe  <= 1'b0;
    end else if (e_s && rw_s) begin
      data_oe  <= 1'b1;
      data_out <= rs_s ? ac_char : {busy, ac};
    end else begin
      data_oe  <= 1'b0;
      data_out <= '0;
    end
  end
`else
  assign data_out = '0;
  assign data_oe  = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_responder.sv
// Scoreboard bench for lcd_responder: directed scenarios plus random writes checked
// against a linear-position reference model of the display.
`timescale 1ns/1ps
module tb_lcd_responder;

  localparam int BUSY_CYCLES  = 40;
  localparam int CLEAR_CYCLES = 1600;
  localparam int FILL_CYCLES  = 32;
  localparam int RD_HOLD      = 6;
  localparam int IDLE_LIMIT   = 5000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       e = 1'b0, rs = 1'b0, rw = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [4:0] scan_addr = 5'd0;
  logic [7:0] data_out, scan_char;
  logic       data_oe, busy, overrun;

  lcd_responder #(
    .BUSY_CYCLES  (BUSY_CYCLES),
    .CLEAR_CYCLES (CLEAR_CYCLES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .e         (e),
    .rs        (rs),
    .rw        (rw),
    .data_in   (data_in),
    .data_out  (data_out),
    .data_oe   (data_oe),
    .busy      (busy),
    .overrun   (overrun),
    .scan_addr (scan_addr),
    .scan_char (scan_char)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         addr;
    logic [7:0] ch;
    logic       ovr;
  } scan_exp_t;

  scan_exp_t  scan_q[$];
  int         busy_q[$];
  logic [7:0] rd_q[$];
  logic       scan_req = 1'b0;
  logic       scan_due = 1'b0;

  // Reference model: cursor as linear position 0..31 (line 0 = 0..15, line 1 = 16..31).
  logic [7:0] mem [32];
  int         pos = 0;
  bit         inc = 1'b1;
  bit         ovr = 1'b0;

  function automatic void chk(string nm, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endfunction

  function automatic int wrap(int p);
    return (p + 32) % 32;
  endfunction

  function automatic void model_cmd(logic [7:0] d);
    if (d == 8'h01) begin
      pos = 0;
      inc = 1'b1;
      for (int i = 0; i < 32; i++) mem[i] = 8'h20;
      busy_q.push_back(FILL_CYCLES + CLEAR_CYCLES);
    end else if (d == 8'h02 || d == 8'h03) begin
      pos = 0;
      busy_q.push_back(CLEAR_CYCLES);
    end else begin
      if (d >= 8'h80)                    pos = (d[6] ? 16 : 0) + int'(d[3:0]);
      else if (d >= 8'h10 && d < 8'h18)  pos = wrap(pos + (d[2] ? 1 : -1));
      else if (d >= 8'h04 && d < 8'h08)  inc = d[1];
      busy_q.push_back(BUSY_CYCLES);
    end
  endfunction

  task automatic bus_cycle(input logic rs_v, input logic rw_v, input logic [7:0] d, input int hold);
    @(posedge clk);
    #1;
    rs = rs_v; rw = rw_v; data_in = d; e = 1'b1;
    repeat (hold) @(posedge clk);
    #1 e = 1'b0;
    repeat (5) @(posedge clk);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < IDLE_LIMIT) begin
      @(negedge clk);
      n++;
    end
    if (n >= IDLE_LIMIT) begin
      checks++;
      errors++;
      $display("FAIL wait_idle busy stuck after %0d cycles", n);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic do_write(input logic rs_v, input logic [7:0] d);
    if (rs_v) begin
      mem[pos] = d;
      pos = wrap(pos + (inc ? 1 : -1));
      busy_q.push_back(BUSY_CYCLES);
    end else begin
      model_cmd(d);
    end
    bus_cycle(rs_v, 1'b0, d, 4);
    wait_idle();
  endtask

  task automatic scan(input int a);
    scan_exp_t it;
    it.addr = a;
    it.ch   = mem[a];
    it.ovr  = ovr;
    scan_q.push_back(it);
    @(posedge clk);
    #1;
    scan_addr = a[4:0];
    scan_req  = 1'b1;
    @(posedge clk);
    #1 scan_req = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    pos = 0;
    inc = 1'b1;
    ovr = 1'b0;
  endtask

  // Monitor: scan results, busy run lengths and read-back windows are popped as they appear.
  always @(posedge clk) scan_due <= scan_req;

  scan_exp_t mon_it;
  int        busy_run = 0;
  int        oe_run = 0;
  int        exp_len;

  always @(negedge clk) begin
    if (scan_due && scan_q.size() > 0) begin
      mon_it = scan_q.pop_front();
      checks++;
      if (scan_char !== mon_it.ch) begin
        errors++;
        $display("FAIL scan_char addr=%0d got=%h exp=%h", mon_it.addr, scan_char, mon_it.ch);
      end
      checks++;
      if (overrun !== mon_it.ovr) begin
        errors++;
        $display("FAIL overrun got=%b exp=%b", overrun, mon_it.ovr);
      end
`ifndef LCD_RESPONDER_READ_EN
      checks++;
      if (data_oe !== 1'b0 || data_out !== 8'h00) begin
        errors++;
        $display("FAIL read_disabled data_oe=%b data_out=%h exp 0/00", data_oe, data_out);
      end
`endif
    end
    if (busy === 1'b1) begin
      busy_run++;
    end else if (busy_run > 0) begin
      checks++;
      if (busy_q.size() == 0) begin
        errors++;
        $display("FAIL busy_len unexpected run=%0d", busy_run);
      end else begin
        exp_len = busy_q.pop_front();
        if (busy_run != exp_len) begin
          errors++;
          $display("FAIL busy_len got=%0d exp=%0d", busy_run, exp_len);
        end
      end
      busy_run = 0;
    end
`ifdef LCD_RESPONDER_READ_EN
    if (data_oe === 1'b1) begin
      oe_run++;
      checks++;
      if (rd_q.size() == 0 || data_out !== rd_q[0]) begin
        errors++;
        $display("FAIL read_data got=%h exp=%h", data_out, (rd_q.size() > 0) ? rd_q[0] : 8'hxx);
      end
    end else if (oe_run > 0) begin
      checks++;
      if (oe_run != RD_HOLD) begin
        errors++;
        $display("FAIL data_oe_len got=%0d exp=%0d", oe_run, RD_HOLD);
      end
      if (rd_q.size() > 0) void'(rd_q.pop_front());
      oe_run = 0;
    end
`endif
  end

  initial begin
    #900000;
    $display("FAIL watchdog timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", int'(busy), 0);
    chk("reset_overrun", int'(overrun), 0);
    chk("reset_data_oe", int'(data_oe), 0);
    chk("reset_data_out", int'(data_out), 0);

    // clear: 32 fill cycles plus clear time, all cells blank
    do_write(1'b0, 8'h01);
    for (int a = 0; a < 32; a++) scan(a);

    // set address 0, write two characters, third write lands at AC=2
    do_write(1'b0, 8'h80);
    do_write(1'b1, 8'h48);
    do_write(1'b1, 8'h69);
    do_write(1'b1, 8'h5A);
    for (int a = 0; a < 4; a++) scan(a);

    // end of line 1 wraps to start of line 0
    do_write(1'b0, 8'hCF);
    do_write(1'b1, 8'h21);
    do_write(1'b1, 8'h33);
    scan(31); scan(0); scan(1);

    // decrement across the line boundary 0x40 -> 0x0F; masked set-address bits
    do_write(1'b0, 8'h04);
    do_write(1'b0, 8'hF0);
    do_write(1'b1, 8'h77);
    do_write(1'b1, 8'h78);
    scan(14); scan(15); scan(16);
    do_write(1'b0, 8'h06);
    do_write(1'b0, 8'h14);
    do_write(1'b1, 8'h41);
    scan(13); scan(14); scan(15);

    // data write while clearing is dropped and flags overrun
    model_cmd(8'h01);
    bus_cycle(1'b0, 1'b0, 8'h01, 4);
    bus_cycle(1'b1, 1'b0, 8'h55, 4);
    ovr = 1'b1;
    wait_idle();
    scan(0); scan(1); scan(31);

`ifdef LCD_RESPONDER_READ_EN
    // status read while clear is in progress
    model_cmd(8'h01);
    bus_cycle(1'b0, 1'b0, 8'h01, 4);
    rd_q.push_back(8'h80);
    bus_cycle(1'b0, 1'b1, 8'h00, RD_HOLD);
    wait_idle();
    do_write(1'b1, 8'h4B);
    do_write(1'b1, 8'h4C);
    do_write(1'b0, 8'h80);
    rd_q.push_back(mem[pos]);
    bus_cycle(1'b1, 1'b1, 8'h00, RD_HOLD);
    pos = wrap(pos + 1);
    repeat (3) @(negedge clk);
    rd_q.push_back({1'b0, 7'(pos)});
    bus_cycle(1'b0, 1'b1, 8'h00, RD_HOLD);
    do_write(1'b1, 8'h4D);
    scan(0); scan(1);
`endif

    // reset keeps DDRAM, clears overrun, returns cursor home
    do_reset();
    do_write(1'b1, 8'h7E);
    scan(0); scan(1); scan(31);

    for (int i = 0; i < 100; i++) begin
      int r;
      logic [7:0] c;
      r = $urandom_range(0, 99);
      if (r < 60) begin
        c = 8'($urandom_range(32, 126));
        do_write(1'b1, c);
      end else if (r < 62) begin
        do_write(1'b0, 8'h01);
      end else begin
        c = 8'($urandom_range(2, 255));
        do_write(1'b0, c);
      end
      scan($urandom_range(0, 31));
    end
    for (int a = 0; a < 32; a += 3) scan(a);

    repeat (4) @(negedge clk);
    chk("busy_q_drained", busy_q.size(), 0);
    chk("scan_q_drained", scan_q.size(), 0);
`ifdef LCD_RESPONDER_READ_EN
    chk("rd_q_drained", rd_q.size(), 0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_responder.md
LCD_RESPONDER -- requirements
Module: lcd_responder

Interface
REQ-001 SHALL have parameter BUSY_CYCLES, default 40, meaning clk cycles busy after a normal command or data write.
REQ-002 SHALL have parameter CLEAR_CYCLES, default 1600, meaning clk cycles busy after clear or return-home, counted after the fill completes.
REQ-003 SHALL have port clk, input, 1, the single clock for all logic.
REQ-004 SHALL have port rst, input, 1, reset; it is synchronous and active-high.
REQ-005 SHALL have port e, input, 1, the LCD enable strobe.
REQ-006 SHALL have port rs, input, 1, register select: 0 selects command/status, 1 selects data.
REQ-007 SHALL have port rw, input, 1, direction: 0 is write, 1 is read.
REQ-008 SHALL have port data_in, input, 8, the bus value from the controller.
REQ-009 SHALL have port data_out, output, 8, the read-back value.
REQ-010 SHALL have port data_oe, output, 1, high when data_out is valid for the bus.
REQ-011 SHALL have port busy, output, 1, the internal busy flag.
REQ-012 SHALL have port overrun, output, 1, a sticky flag set when a write arrives while busy.
REQ-013 SHALL have port scan_addr, input, 5, the display-scan character index.
REQ-014 SHALL have port scan_char, output, 8, DDRAM[scan_addr], valid one cycle after scan_addr.

Function
REQ-015 SHALL pass e, rs, rw and data_in through an identical 2-flop synchronizer; strobe = synchronized e falling edge (1 then 0).
REQ-016 SHALL act on the registered rs/rw/data captured in the same cycle as the strobe.
REQ-017 SHALL hold a 7-bit address counter AC; DDRAM index = {AC[6],AC[3:0]}; 32x8 DDRAM.
REQ-018 SHALL implement FSM states IDLE, FILL, BUSY; busy=1 in FILL and BUSY.
REQ-019 SHALL apply AC step: increment 0x0F->0x40, 0x4F->0x00; decrement 0x00->0x4F, 0x40->0x0F; direction set by I/D.
REQ-020 SHALL, on write rs=0 with data 0x01 (clear): AC=0, I/D=1, enter FILL and write 0x20 to indices 0..31 at one per cycle, then enter BUSY for CLEAR_CYCLES.
REQ-021 SHALL, on write rs=0 with data 0x02/0x03 (home): AC=0, enter BUSY for CLEAR_CYCLES; DDRAM unchanged.
REQ-022 SHALL, on 0x04-0x07: I/D=data[1]; on 0x08-0x0F: store D=data[2]; on 0x10-0x1F with data[3]=0: step AC with direction data[2]; on 0x18-0x1F, 0x20-0x3F and 0x40-0x7F: no state effect; every one of these enters BUSY for BUSY_CYCLES.
REQ-023 SHALL, on 0x80-0xFF: AC={data[6],2'b00,data[3:0]} (illegal bits masked), then BUSY for BUSY_CYCLES.
REQ-024 SHALL, on write rs=1: DDRAM[AC]=data, step AC, then BUSY for BUSY_CYCLES.
REQ-025 SHALL ignore any write strobe while busy=1 except for setting overrun; state is unchanged.
REQ-026 SHALL return busy to 0 exactly BUSY_CYCLES (or CLEAR_CYCLES) cycles after entering BUSY, then go to IDLE.
REQ-027 SHALL give the scan port priority-free access: it is a separate read port and is never stalled by FILL.

Reset
REQ-028 SHALL, on rst=1 at a clk edge: state IDLE, AC=0, I/D=1, D=0, busy=0, overrun=0, data_out=0, data_oe=0, synchronizer flops=0.
REQ-029 SHALL leave DDRAM contents unaffected by rst; rst asserted during FILL or BUSY aborts immediately to IDLE.

Configuration
REQ-030 SHALL, with LCD_RESPONDER_READ_EN defined, serve reads while synchronized e=1 and rw=1: data_oe=1; rs=0 returns {busy,AC}; rs=1 returns DDRAM[AC] and steps AC at the strobe. Reads are allowed while busy.
REQ-031 SHALL, without LCD_RESPONDER_READ_EN, hold data_out=0 and data_oe=0 and treat read strobes as no-ops.

Structure
REQ-032 SHALL place command opcode/mask constants, the state enum and the AC step function in package lcd_pkg.
REQ-033 SHALL implement DDRAM as sub-module lcd_ddram: 32x8, one write port and two synchronous read ports.

Verification
REQ-034 SHALL cover: after reset, write 0x01 -> busy=1 for 32+1600 cycles, all scan_char=0x20, AC=0.
REQ-035 SHALL cover: write 0x80, then data 0x48,0x69 -> DDRAM[0]=0x48, DDRAM[1]=0x69, AC=0x02.
REQ-036 SHALL cover: set AC=0x4F, write data 0x21 -> DDRAM[31]=0x21, AC=0x00.
REQ-037 SHALL cover: write 0x04 (decrement), then AC=0x40, write data -> AC=0x0F.
REQ-038 SHALL cover: a data write during busy -> DDRAM unchanged, overrun=1 until rst.
REQ-039 SHALL cover, with LCD_RESPONDER_READ_EN: a status read during clear -> data_out=0x80, data_oe=1 only while e is high.
